// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling with a runtime
// bit period, rdy/clr_rdy handshake and sticky framing/overrun flags.
module uart_rx #(
    parameter int BAUD_DIV_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX,
    input  logic [BAUD_DIV_W-1:0] baud_div,
    input  logic                  clr_rdy,
    input  logic                  clr_err,
    output logic [7:0]            rx_data,
    output logic                  rdy,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    localparam logic [BAUD_DIV_W-1:0] CNT_ONE = 1;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [BAUD_DIV_W-1:0] div_q;
    logic [BAUD_DIV_W-1:0] baud_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;

    // Clears are applied first so that a same-cycle set from the FSM wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            div_q     <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rdy       <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_busy <= (state != IDLE);

            if (clr_rdy) begin
                rdy <= 1'b0;
            end
            if (clr_err) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                        div_q    <= baud_div;
                    end
                end

                // Half a bit in, the start bit must still be low or it was a glitch.
                START: begin
                    if (baud_cnt == (div_q >> 1)) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (baud_cnt == div_q) begin
                        shift    <= {rx_s, shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (baud_cnt == div_q) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            if (!rdy || clr_rdy) begin
                                rx_data <= shift;
                                rdy     <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end

                // A line held low after a bad stop bit must not look like a new start.
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
